// File: rtl/imm_pack.sv
// Packs a 32-bit immediate into the RV32I immediate fields of a base instruction,
// flagging values that the selected format cannot represent. Two-stage valid/ready pipe.
module imm_pack #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      base_inst,
  input  logic [2:0]       imm_type,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] NOIMM = 3'd0;
  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  function automatic logic [31:0] pack_imm(input logic [31:0] base,
                                           input logic [2:0]  typ,
                                           input logic [31:0] val);
    logic [31:0] r;
    r = base;
    case (typ)
      ITYPE: r[31:20] = val[11:0];
      STYPE: begin
        r[31:25] = val[11:5];
        r[11:7]  = val[4:0];
      end
      BTYPE: begin
        r[31]    = val[12];
        r[30:25] = val[10:5];
        r[11:8]  = val[4:1];
        r[7]     = val[11];
      end
      UTYPE: r[31:12] = val[31:12];
      JTYPE: begin
        r[31]    = val[20];
        r[30:21] = val[10:1];
        r[20]    = val[11];
        r[19:12] = val[19:12];
      end
      default: r = base;
    endcase
    return r;
  endfunction

  // A field is representable when every bit above it is a copy of its sign bit.
  function automatic logic imm_err(input logic [2:0]  typ,
                                   input logic [31:0] val);
    logic e;
    case (typ)
      NOIMM:         e = 1'b0;
      ITYPE, STYPE:  e = !((&val[31:11]) || !(|val[31:11]));
      BTYPE:         e = !((&val[31:12]) || !(|val[31:12])) || val[0];
      UTYPE:         e = |val[11:0];
      JTYPE:         e = !((&val[31:20]) || !(|val[31:20])) || val[0];
      default:       e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic        vld_p1;
  logic [31:0] base_p1;
  logic [2:0]  type_p1;
  logic [31:0] imm_p1;
  logic        vld_p2;
  logic [31:0] inst_p2;
  logic        err_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic        adv_p2;

  assign adv_p2   = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv_p2;

  // Stage 1: capture the raw beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      base_p1 <= base_inst;
      type_p1 <= imm_type;
      imm_p1  <= imm;
    end
  end

  // Stage 2: packed instruction and representability flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      inst_p2 <= '0;
      err_p2  <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        inst_p2 <= pack_imm(base_p1, type_p1, imm_p1);
        err_p2  <= imm_err(type_p1, imm_p1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p2 <= '0;
    end else if (err_clr) begin
      cnt_p2 <= '0;
    end else if (vld_p2 && out_ready && err_p2) begin
      cnt_p2 <= sat_inc(cnt_p2);
    end
  end

  assign out_valid = vld_p2;
  assign out_inst  = inst_p2;
  assign out_err   = err_p2;
  assign err_cnt   = cnt_p2;

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: arithmetic reference model with an in-order scoreboard, plus
// directed vectors with hand-computed results.
module tb_imm_pack;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      base_inst = '0;
  logic [2:0]       imm_type = '0;
  logic [31:0]      imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_inst;
  logic             out_err;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  imm_pack #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .base_inst(base_inst), .imm_type(imm_type), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   nchecks = 0;
  int   nerrors = 0;
  int   mcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ranges as signed integers, fields placed with shifts and masks.
  function automatic exp_t model(input logic [31:0] b, input logic [2:0] t, input logic [31:0] v);
    exp_t e;
    int   s;
    s = int'(v);
    case (t)
      3'd0: begin e.inst = b; e.err = 1'b0; end
      3'd1: begin
        e.inst = (b & 32'h000FFFFF) | ((v & 32'hFFF) << 20);
        e.err  = !(s >= -2048 && s <= 2047);
      end
      3'd2: begin
        e.inst = (b & 32'h01FFF07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
        e.err  = !(s >= -2048 && s <= 2047);
      end
      3'd3: begin
        e.inst = (b & 32'h01FFF07F) | (((v >> 12) & 1) << 31) | (((v >> 5) & 32'h3F) << 25)
               | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 1) << 7);
        e.err  = !(s >= -4096 && s <= 4095) || (s % 2 != 0);
      end
      3'd4: begin
        e.inst = (b & 32'hFFF) | (v & 32'hFFFFF000);
        e.err  = (v & 32'hFFF) != 0;
      end
      3'd5: begin
        e.inst = (b & 32'hFFF) | (((v >> 20) & 1) << 31) | (((v >> 1) & 32'h3FF) << 21)
               | (((v >> 11) & 1) << 20) | (v & 32'h000FF000);
        e.err  = !(s >= -1048576 && s <= 1048575) || (s % 2 != 0);
      end
      default: begin e.inst = b; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Every-cycle scoreboard compare
  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_err_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd0);
    end else begin
      exp_rdy = (q.size() < 2) || out_ready;
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      if (q.size() == 0) chk("spurious_valid", {31'b0, out_valid}, 32'd0);
      chk("err_cnt", {{(32-CNT_W){1'b0}}, err_cnt}, mcnt);
      if (out_valid && q.size() > 0) begin
        chk("out_inst", out_inst, q[0].inst);
        chk("out_err", {31'b0, out_err}, {31'b0, q[0].err});
        if (out_ready) begin
          if (!err_clr && q[0].err && mcnt < (1 << CNT_W) - 1) mcnt++;
          void'(q.pop_front());
        end
      end
      if (err_clr) mcnt = 0;
      if (in_valid && exp_rdy) q.push_back(model(base_inst, imm_type, imm));
    end
  end

  task automatic drive(input logic [31:0] b, input logic [2:0] t, input logic [31:0] v);
    logic acc;
    int   n;
    in_valid = 1'b1; base_inst = b; imm_type = t; imm = v;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input logic [31:0] b, input logic [2:0] t, input logic [31:0] v,
                        input logic [31:0] xi, input logic xe, input string name);
    int n;
    drive(b, t, v);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk({name, "_latency"}, n, 32'd2);
    chk({name, "_inst"}, out_inst, xi);
    chk({name, "_err"}, {31'b0, out_err}, {31'b0, xe});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_err", {31'b0, out_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    single(32'h00000013, 3'd1, 32'hFFFFFFFF, 32'hFFF00013, 1'b0, "itype");
    single(32'h00002023, 3'd2, 32'h000007FF, 32'h7E002FA3, 1'b0, "stype");
    single(32'h00000063, 3'd3, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, "btype");
    single(32'h00000063, 3'd3, 32'h00000003, 32'h00000163, 1'b1, "btype_odd");
    @(negedge clk);
    chk("cnt_after_b", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd1);
    @(posedge clk); #1;
    single(32'h00000037, 3'd4, 32'h12345000, 32'h12345037, 1'b0, "utype");
    single(32'h0000006F, 3'd5, 32'h00000800, 32'h0010006F, 1'b0, "jtype");
    single(32'hABCDE013, 3'd0, 32'hFFFFFFFF, 32'hABCDE013, 1'b0, "noimm");
    single(32'h00000013, 3'd6, 32'h00000000, 32'h00000013, 1'b1, "code6");
    single(32'h00000013, 3'd1, 32'h00000800, 32'h80000013, 1'b1, "itype_ovf");
    single(32'h00000037, 3'd4, 32'h00000001, 32'h00000037, 1'b1, "utype_low");
    single(32'h0000006F, 3'd5, 32'hFFF00000, 32'h8000006F, 1'b0, "jtype_min");
    @(negedge clk);
    chk("cnt_sat_prev", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd3);
    @(posedge clk); #1;

    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("cnt_clr", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd0);

    // Backpressure: two beats fill the pipe, then stall three cycles
    out_ready = 1'b0;
    drive(32'h00000013, 3'd1, 32'h00000001);
    drive(32'h00002023, 3'd2, 32'hFFFFF800);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drive(32'h00000063, 3'd3, 32'h00000FFE);
    drive(32'h0000006F, 3'd5, 32'h000FFFFE);
    in_valid = 1'b0;
    drain();

    // Five erroring beats back to back saturate the counter
    for (int i = 0; i < 5; i++) drive(32'h00000013, 3'd7, i);
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("cnt_sat", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd3);
    @(posedge clk); #1;

    // Clear wins over an erroring transfer in the same cycle
    drive(32'h00000037, 3'd4, 32'h00000FFF);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_priority", {{(32-CNT_W){1'b0}}, err_cnt}, 32'd0);
    drain();

    // Reset while beats are in flight
    drive(32'h00000013, 3'd1, 32'h00000010);
    drive(32'h00000013, 3'd1, 32'h00000020);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_inst", out_inst, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    single(32'h00000013, 3'd1, 32'hFFFFF800, 32'h80000013, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
